// File: rtl/rx_fifo_pkg.sv
// rx_fifo_pkg
// Shared defaults and helpers for the rx_sync_fifo codebase slice.
//   RX_FIFO_DATA_W_DEF : default word width
//   RX_FIFO_DEPTH_DEF  : default entry count
//   rx_fifo_ptr_w()    : pointer width for a given depth
package rx_fifo_pkg;

    localparam int RX_FIFO_DATA_W_DEF = 8;
    localparam int RX_FIFO_DEPTH_DEF  = 8;

    // A depth of 1 would give a zero-width pointer, so clamp to one bit.
    function automatic int rx_fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// rx_fifo_mem
// Storage array for rx_sync_fifo. It has one synchronous write port and one
// asynchronous read port. The array is not reset.
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write word
//   raddr : read address
//   rdata : read word, combinational from raddr
module rx_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_sync_fifo.sv
// rx_sync_fifo
// Single-clock show-ahead FIFO. Pointers, occupancy and flags are kept here,
// and the storage array is in rx_fifo_mem.
// The optional sticky error flags are enabled by the macro RX_FIFO_ERR_EN.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   w_enable     : push request
//   w_data       : push word
//   r_enable     : pop request
//   r_data       : head word (show-ahead); 0 while empty
//   full         : count == DEPTH (registered)
//   empty        : count == 0 (registered)
//   almost_full  : count >= AF_LVL (registered)
//   almost_empty : count <= AE_LVL (registered)
//   count        : current occupancy, 0..DEPTH
//   err_clr      : clears overflow/underflow   (RX_FIFO_ERR_EN only)
//   overflow     : sticky, push dropped while full   (RX_FIFO_ERR_EN only)
//   underflow    : sticky, pop requested while empty (RX_FIFO_ERR_EN only)
module rx_sync_fifo
    import rx_fifo_pkg::*;
#(
    parameter int DATA_W = RX_FIFO_DATA_W_DEF,
    parameter int DEPTH  = RX_FIFO_DEPTH_DEF,
    parameter int AF_LVL = DEPTH - 1,
    parameter int AE_LVL = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          w_enable,
    input  logic [DATA_W-1:0]             w_data,
    input  logic                          r_enable,
    output logic [DATA_W-1:0]             r_data,
`ifdef RX_FIFO_ERR_EN
    input  logic                          err_clr,
    output logic                          overflow,
    output logic                          underflow,
`endif
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [rx_fifo_ptr_w(DEPTH):0] count
);

    localparam int PTR_W = rx_fifo_ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LVL);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LVL);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] mem_rdata;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count_nxt;

    // While the FIFO is full, a push is accepted only together with a pop, because the pop frees the slot.
    // A pop while empty is never satisfied from the incoming word.
    assign push = w_enable && (!full || r_enable);
    assign pop  = r_enable && !empty;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // The flags are registered from count_nxt so that they change in the same cycle as count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_CNT);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_CNT);
            almost_empty <= (count_nxt <= AE_CNT);
        end
    end

`ifdef RX_FIFO_ERR_EN
    logic ovf_set;
    logic udf_set;

    assign ovf_set = w_enable && full && !r_enable;
    assign udf_set = r_enable && empty;

    // If a set event and err_clr happen in the same cycle, the set event wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (udf_set) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`endif

    // The storage is not reset, so a push during reset must not write to it.
    rx_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push && !rst),
        .waddr (wr_ptr),
        .wdata (w_data),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    assign r_data = empty ? '0 : mem_rdata;

endmodule

// File: tb/tb_rx_sync_fifo.sv
// tb_rx_sync_fifo
// Tests rx_sync_fifo (DATA_W=8, DEPTH=8) against a queue-based reference model.
// The bench runs the directed scenarios first and then a randomized traffic phase.
// Build with RX_FIFO_ERR_EN defined to also cover the sticky error flags.
module tb_rx_sync_fifo;

    localparam int DW     = 8;
    localparam int DEPTH  = 8;
    localparam int AF_LVL = DEPTH - 1;
    localparam int AE_LVL = 1;

    logic          clk;
    logic          rst;
    logic          w_enable;
    logic [DW-1:0] w_data;
    logic          r_enable;
    logic [DW-1:0] r_data;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [3:0]    count;
    logic          err_clr;
`ifdef RX_FIFO_ERR_EN
    logic          overflow;
    logic          underflow;
`endif

    rx_sync_fifo #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .AF_LVL (AF_LVL),
        .AE_LVL (AE_LVL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .w_enable     (w_enable),
        .w_data       (w_data),
        .r_enable     (r_enable),
        .r_data       (r_data),
`ifdef RX_FIFO_ERR_EN
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [DW-1:0] q[$];
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, then compare all outputs.
    task automatic step(input logic w, input logic [DW-1:0] wd, input logic r,
                        input logic rs, input logic clr);
        int  sz;
        logic m_full;
        logic m_empty;
        w_enable = w;
        w_data   = wd;
        r_enable = r;
        rst      = rs;
        err_clr  = clr;
        @(posedge clk);
        sz      = q.size();
        m_full  = (sz == DEPTH);
        m_empty = (sz == 0);
        if (rs) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && m_full && !r) m_ovf = 1'b1;
            else if (clr)          m_ovf = 1'b0;
            if (r && m_empty)      m_udf = 1'b1;
            else if (clr)          m_udf = 1'b0;
            if (r && !m_empty) void'(q.pop_front());
            if (w && (!m_full || r)) q.push_back(wd);
        end
        #1;
        sz = q.size();
        chk("count",        32'(count),        32'(sz));
        chk("full",         32'(full),         32'(sz == DEPTH));
        chk("empty",        32'(empty),        32'(sz == 0));
        chk("almost_full",  32'(almost_full),  32'(sz >= AF_LVL));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= AE_LVL));
        chk("r_data",       32'(r_data),       (sz == 0) ? 32'd0 : 32'(q[0]));
`ifdef RX_FIFO_ERR_EN
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_udf));
`endif
    endtask

    initial begin
        w_enable = 1'b0;
        w_data   = '0;
        r_enable = 1'b0;
        rst      = 1'b0;
        err_clr  = 1'b0;

        // reset state
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // fill 0x11..0x18; almost_full is expected from count 7
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0, 1'b0);
        chk("full_after_fill", 32'(full), 32'd1);

        // push while full is dropped, and err_clr clears overflow
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // push and pop together while full; 0x55 should come out last
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("empty_after_drain", 32'(empty), 32'd1);

        // push and pop together while empty: no bypass, and underflow is set
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // hold count at 3 with pairs so that the pointers wrap
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0, 1'b0);
        chk("count_after_wrap", 32'(count), 32'd3);

        // reset at count 5 together with a push
        step(1'b1, 8'hD0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hD1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hD2, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // randomized traffic with a changing push/pop bias
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = ((i / 100) % 2 == 0) ? 70 : 30;
            step($urandom_range(99) < bias,
                 8'($urandom),
                 $urandom_range(99) < (100 - bias),
                 $urandom_range(99) < 2,
                 $urandom_range(99) < 5);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/rx_sync_fifo.md
RX_SYNC_FIFO -- requirements
Module: rx_sync_fifo

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits; SHALL be at least 1.
REQ-002 Parameter DEPTH, default 8, entry count; SHALL be a power of two and at least 2.
REQ-003 Parameter AF_LVL, default DEPTH-1, almost_full threshold in entries.
REQ-004 Parameter AE_LVL, default 1, almost_empty threshold in entries.
REQ-005 Ports: clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 w_enable  in  1  push request; w_data  in  DATA_W  push word.
REQ-008 r_enable  in  1  pop request; r_data  out  DATA_W  head word, show-ahead.
REQ-009 full, empty, almost_full, almost_empty  out  1  status flags, all registered.
REQ-010 count  out  $clog2(DEPTH)+1  current occupancy.
REQ-011 Under RX_FIFO_ERR_EN only: err_clr  in  1, overflow  out  1, underflow  out  1.

Function
REQ-012 A push is accepted when w_enable=1 and (full=0, or r_enable=1 with full=1); the word is stored at wr_ptr and wr_ptr advances.
REQ-013 A pop is accepted when r_enable=1 and empty=0; rd_ptr advances.
REQ-014 r_data SHALL show mem[rd_ptr] combinationally while empty=0, and SHALL be 0 while empty=1; a pushed word is visible the cycle after the push.
REQ-015 Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH with no bubble.
REQ-016 count +1 on push only, -1 on pop only, unchanged on both or neither; count SHALL stay within 0..DEPTH.
REQ-017 full=1 iff count==DEPTH; empty=1 iff count==0; both are updated in the same cycle as count.
REQ-018 almost_full=1 iff count>=AF_LVL; almost_empty=1 iff count<=AE_LVL.
REQ-019 Push while full without a simultaneous pop: the word is dropped and state is unchanged.
REQ-020 Pop while empty: ignored, even if a push occurs in the same cycle (no bypass); the pushed word is stored.
REQ-021 Simultaneous push and pop when full: both succeed and count stays DEPTH.

Reset
REQ-022 With rst=1 at a clock edge: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, r_data=0, overflow=0, underflow=0.
REQ-023 Reset mid-operation discards all contents; push and pop requests in the reset cycle are ignored.
REQ-024 Storage contents are not reset.

Configuration
REQ-025 Macro RX_FIFO_ERR_EN defined: overflow becomes sticky 1 on a REQ-019 drop, underflow becomes sticky 1 on a pop while empty; both clear on err_clr=1; a set event in the same cycle as err_clr takes precedence.
REQ-026 Macro undefined: the err_clr, overflow and underflow ports and their logic are absent; all other behaviour is identical.

Structure
REQ-027 Package rx_fifo_pkg SHALL hold RX_FIFO_DATA_W_DEF=8 and RX_FIFO_DEPTH_DEF=8, and a ptr width function based on $clog2.
REQ-028 Storage SHALL be in sub-module rx_fifo_mem: write port (clk, we, waddr, wdata), asynchronous read port (raddr, rdata), no reset.
REQ-029 Pointer, count and flag control SHALL reside in rx_sync_fifo.

Verification
REQ-030 Reset, then push 0x11..0x18 (DEPTH=8) -> full=1, count=8, almost_full asserted at count 7; pops return 0x11..0x18 in order; then empty=1, r_data=0.
REQ-031 Fill to full, push 0xAA alone -> dropped, count stays 8, overflow=1 (ERR_EN); err_clr pulse -> overflow=0.
REQ-032 Full, simultaneous push 0x55 and pop -> head popped, count=8, 0x55 read last after 7 more pops.
REQ-033 Empty, simultaneous push 0x3C and pop -> count=1, r_data=0x3C next cycle, underflow=1 (ERR_EN).
REQ-034 Run 20 push/pop pairs at count 3 to force pointer wrap -> data order preserved, count stays 3.
REQ-035 Assert rst at count 5 together with a push -> next cycle count=0, empty=1, r_data=0.
